// File: rtl/mem_arb_pkg.sv
// Shared widths and helpers for the multi-requester RAM port arbiter.
package mem_arb_pkg;

    // Wide enough to count up to MAX_BURST-1 for any MAX_BURST in 1..255.
    localparam int BURST_CNT_W = 8;

    function automatic int be_width(input int data_width);
        return (data_width + 7) / 8;
    endfunction

    function automatic int id_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority selector: first valid requester at or above ptr, wrapping.
module rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id,
    output logic               any_grant
);

    logic [ID_W-1:0] idx;

    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        grant     = '0;
        grant_id  = '0;
        any_grant = 1'b0;
        idx       = '0;
        // Scan from the farthest offset down so the nearest valid one is the last written.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = ID_W'((int'(ptr) + k) % NUM_REQ);
            if (valid[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                grant_id   = idx;
                any_grant  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one RAM port among NUM_REQ requesters with round-robin and burst locking.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter  int NUM_REQ       = 4,
    parameter  int MEM_DATAWIDTH = 128,
    parameter  int MEM_ADDRWIDTH = 14,
    parameter  int MAX_BURST     = 8,
    localparam int BE            = be_width(MEM_DATAWIDTH),
    localparam int ID_W          = id_width(NUM_REQ)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ-1:0]               req_lock,
    input  logic [NUM_REQ*BE-1:0]            req_we,
    input  logic [NUM_REQ*MEM_ADDRWIDTH-1:0] req_addr,
    input  logic [NUM_REQ*MEM_DATAWIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [MEM_DATAWIDTH-1:0]         rsp_rdata,
    output logic                             mem_en,
    output logic [BE-1:0]                    mem_we,
    output logic [MEM_ADDRWIDTH-1:0]         mem_addr,
    output logic [MEM_DATAWIDTH-1:0]         mem_din,
    input  logic [MEM_DATAWIDTH-1:0]         mem_dout
);

    logic [ID_W-1:0]        rr_ptr, owner, arb_id, win_id, next_ptr;
    logic [BURST_CNT_W-1:0] burst_cnt, base_cnt;
    logic                   lock_active, lock_hold, arb_any, accept, keep_lock;
    logic [NUM_REQ-1:0]     arb_grant;
    logic [BE-1:0]          win_we;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .valid     (req_valid),
        .ptr       (rr_ptr),
        .grant     (arb_grant),
        .grant_id  (arb_id),
        .any_grant (arb_any)
    );

    always_comb begin
        // A lock only counts while its owner keeps asking; otherwise arbitrate normally.
        lock_hold = lock_active && req_valid[owner];
        win_id    = lock_hold ? owner : arb_id;
        accept    = reset && (lock_hold || arb_any);
        req_ready = accept ? (NUM_REQ'(1) << win_id) : '0;
        win_we    = req_we[win_id*BE +: BE];

        // RAM controls go straight to the port; the RAM's own output register is the only stage.
        mem_en    = accept;
        mem_we    = accept ? win_we : '0;
        mem_addr  = accept ? req_addr[win_id*MEM_ADDRWIDTH +: MEM_ADDRWIDTH] : '0;
        mem_din   = accept ? req_wdata[win_id*MEM_DATAWIDTH +: MEM_DATAWIDTH] : '0;

        base_cnt  = lock_hold ? burst_cnt : '0;
        keep_lock = req_lock[win_id] && (int'(base_cnt) + 1 < MAX_BURST);
        next_ptr  = (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
    end

    assign rsp_rdata = mem_dout;

    // NOTE: state uses non-blocking assignments and an asynchronous active-low clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr      <= '0;
            owner       <= '0;
            burst_cnt   <= '0;
            lock_active <= 1'b0;
            rsp_valid   <= '0;
        end else begin
            // Writes are posted; only reads produce a strobe one cycle later.
            rsp_valid <= (accept && win_we == '0) ? req_ready : '0;
            if (accept) begin
                if (keep_lock) begin
                    lock_active <= 1'b1;
                    owner       <= win_id;
                    burst_cnt   <= base_cnt + 1'b1;
                end else begin
                    lock_active <= 1'b0;
                    burst_cnt   <= '0;
                    rr_ptr      <= next_ptr;
                end
            end else if (lock_active) begin
                lock_active <= 1'b0;
                burst_cnt   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed checks of mem_port_arbiter against a rule-level model and RAM model.
module tb_mem_port_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int AW = 8;
    localparam int MB = 8;
    localparam int BE = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req_valid, req_ready, req_lock, rsp_valid;
    logic [N*BE-1:0]   req_we;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_wdata;
    logic [DW-1:0]     rsp_rdata, mem_din, mem_dout;
    logic              mem_en;
    logic [BE-1:0]     mem_we;
    logic [AW-1:0]     mem_addr;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .NUM_REQ(N), .MEM_DATAWIDTH(DW), .MEM_ADDRWIDTH(AW), .MAX_BURST(MB)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_lock(req_lock),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Stimulus for the next cycle, per requester.
    logic [N-1:0]  drv_valid, drv_lock;
    logic [BE-1:0] drv_we    [N];
    logic [AW-1:0] drv_addr  [N];
    logic [DW-1:0] drv_wdata [N];

    // RAM behaviour: one-cycle read latency, output holds during writes.
    logic [DW-1:0] ram [256];

    // Reference arbiter state kept as plain rules.
    int            m_ptr, m_owner, m_cnt;
    bit            m_locked, m_rsp_pending;
    int            m_rsp_id;
    logic [DW-1:0] m_rsp_data;

    // Last observed values, for the directed scenarios.
    logic [N-1:0]  g_ready, g_rsp_valid;
    logic [DW-1:0] g_rsp_rdata;

    function automatic int model_winner();
        if (m_locked && drv_valid[m_owner]) return m_owner;
        for (int k = 0; k < N; k++)
            if (drv_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_owner = 0; m_cnt = 0; m_locked = 0; m_rsp_pending = 0; m_rsp_id = 0;
    endtask

    task automatic set_idle();
        drv_valid = '0; drv_lock = '0;
        for (int i = 0; i < N; i++) begin
            drv_we[i] = '0; drv_addr[i] = '0; drv_wdata[i] = '0;
        end
    endtask

    task automatic run_cycle();
        int            w, used;
        logic [N-1:0]  exp_ready;
        logic          cap_en;
        logic [BE-1:0] cap_we;
        logic [AW-1:0] cap_addr;
        logic [DW-1:0] cap_din;
        @(negedge clk);
        req_valid = drv_valid;
        req_lock  = drv_lock;
        for (int i = 0; i < N; i++) begin
            req_we[i*BE +: BE]    = drv_we[i];
            req_addr[i*AW +: AW]  = drv_addr[i];
            req_wdata[i*DW +: DW] = drv_wdata[i];
        end
        #1;
        check("rsp_valid", rsp_valid, m_rsp_pending ? (N'(1) << m_rsp_id) : N'(0));
        if (m_rsp_pending) check("rsp_rdata", rsp_rdata, m_rsp_data);
        w = model_winner();
        exp_ready = (w >= 0) ? (N'(1) << w) : N'(0);
        check("req_ready", req_ready, exp_ready);
        check("mem_en",    mem_en,    w >= 0);
        check("mem_we",    mem_we,    (w >= 0) ? drv_we[w]    : BE'(0));
        check("mem_addr",  mem_addr,  (w >= 0) ? drv_addr[w]  : AW'(0));
        check("mem_din",   mem_din,   (w >= 0) ? drv_wdata[w] : DW'(0));
        g_ready = req_ready; g_rsp_valid = rsp_valid; g_rsp_rdata = rsp_rdata;
        cap_en = mem_en; cap_we = mem_we; cap_addr = mem_addr; cap_din = mem_din;

        m_rsp_pending = 0;
        if (w >= 0) begin
            if (drv_we[w] == '0) begin
                m_rsp_pending = 1;
                m_rsp_id      = w;
                m_rsp_data    = ram[drv_addr[w]];
            end
            used = (m_locked && m_owner == w) ? m_cnt + 1 : 1;
            if (drv_lock[w] && used < MB) begin
                m_locked = 1; m_owner = w; m_cnt = used;
            end else begin
                m_locked = 0; m_cnt = 0; m_ptr = (w + 1) % N;
            end
        end else if (m_locked) begin
            m_locked = 0; m_cnt = 0;
        end

        @(posedge clk);
        if (cap_en) begin
            if (cap_we == '0) mem_dout = ram[cap_addr];
            else for (int b = 0; b < BE; b++)
                if (cap_we[b]) ram[cap_addr][b*8 +: 8] = cap_din[b*8 +: 8];
        end
    endtask

    // Hold reset low for a cycle with every requester asking; nothing may be granted.
    task automatic reset_pulse(input bit immediate);
        if (!immediate) @(negedge clk);
        reset = 1'b0;
        req_valid = '1;
        req_we    = '0;
        @(negedge clk);
        #1;
        check("rst_req_ready", req_ready, N'(0));
        check("rst_mem_en",    mem_en,    1'b0);
        check("rst_mem_we",    mem_we,    BE'(0));
        check("rst_rsp_valid", rsp_valid, N'(0));
        @(negedge clk);
        reset = 1'b1;
        req_valid = '0;
        model_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc, pulses;
        for (int a = 0; a < 256; a++) ram[a] = DW'(a) * 32'h0101_0101 ^ 32'h3C00_00C3;
        mem_dout = '0;
        reset = 1'b0;
        req_valid = '0; req_lock = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        set_idle();
        model_reset();
        reset_pulse(0);

        // All four read continuously without lock: strict rotation.
        set_idle();
        drv_valid = 4'b1111;
        for (int i = 0; i < N; i++) drv_addr[i] = AW'(i + 1);
        for (int c = 0; c < 8; c++) begin
            run_cycle();
            check("rotation", g_ready, N'(1) << (c % N));
        end

        // Write from 1 then read by 2 at the same address.
        set_idle();
        drv_valid = 4'b0010; drv_we[1] = 4'hF; drv_addr[1] = 8'h10; drv_wdata[1] = 32'hA5A5_A5A5;
        run_cycle();
        set_idle();
        drv_valid = 4'b0100; drv_addr[2] = 8'h10;
        run_cycle();
        check("raw_grant", g_ready, 4'b0100);
        set_idle();
        run_cycle();
        check("raw_rsp_valid", g_rsp_valid, 4'b0100);
        check("raw_rsp_rdata", g_rsp_rdata, 32'hA5A5_A5A5);

        // Locked burst from 0 with 3 waiting: eight grants to 0, then 3.
        reset_pulse(0);
        set_idle();
        drv_valid = 4'b1001; drv_lock = 4'b0001;
        for (int c = 0; c < MB + 1; c++) begin
            run_cycle();
            check("burst_grant", g_ready, (c < MB) ? 4'b0001 : 4'b1000);
        end

        // 2 locks ahead of a pointer favouring 3, then drops valid after three accepts.
        reset_pulse(0);
        set_idle();
        drv_valid = 4'b0100;
        run_cycle();
        drv_lock = 4'b0100;
        run_cycle();
        drv_valid = 4'b1100;
        for (int c = 0; c < 2; c++) begin
            run_cycle();
            check("lock_hold", g_ready, 4'b0100);
        end
        drv_valid = 4'b1000;
        run_cycle();
        check("lock_release", g_ready, 4'b1000);

        // Reset arrives with a read in flight: its strobe is lost, pointer returns to 0.
        set_idle();
        drv_valid = 4'b0010;
        run_cycle();
        reset_pulse(1);
        set_idle();
        run_cycle();
        check("no_stale_rsp", g_rsp_valid, N'(0));
        drv_valid = 4'b1111;
        run_cycle();
        check("post_reset_first", g_ready, 4'b0001);

        // Lone requester 3 streams ten reads.
        set_idle();
        run_cycle();
        drv_valid = 4'b1000;
        acc = 0; pulses = 0;
        for (int c = 0; c < 11; c++) begin
            if (c == 10) drv_valid = '0;
            drv_addr[3] = AW'(c);
            run_cycle();
            if (g_ready == 4'b1000) acc++;
            if (g_rsp_valid == 4'b1000) pulses++;
        end
        run_cycle();
        if (g_rsp_valid == 4'b1000) pulses++;
        check("solo_accepts", acc, 10);
        check("solo_pulses", pulses, 10);

        // Random traffic with frequent locks and read-after-write on a small address window.
        for (int c = 0; c < 400; c++) begin
            drv_valid = N'($urandom);
            drv_lock  = N'($urandom | $urandom);
            for (int i = 0; i < N; i++) begin
                drv_we[i]    = ($urandom_range(0, 1) == 0) ? BE'(0) : BE'($urandom);
                drv_addr[i]  = AW'($urandom_range(0, 15));
                drv_wdata[i] = $urandom;
            end
            run_cycle();
        end
        set_idle();
        run_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters sharing one RAM port (2..8).
REQ-002 SHALL have parameter MEM_DATAWIDTH, default 128: RAM word width.
REQ-003 SHALL have parameter MEM_ADDRWIDTH, default 14: RAM word-address width.
REQ-004 SHALL have parameter MAX_BURST, default 8: maximum consecutive accepts per locked grant (1..255).
REQ-005 SHALL use one clock; reset is asynchronous and active-low.
REQ-006 clk  in  1  sole clock; all state on rising edge.
REQ-007 reset  in  1  asynchronous active-low reset.
REQ-008 req_valid  in  NUM_REQ  per-requester request valid.
REQ-009 req_ready  out  NUM_REQ  per-requester accept; at most one bit high.
REQ-010 req_lock  in  NUM_REQ  requester asks to keep the grant for the next request.
REQ-011 req_we  in  NUM_REQ*BE  byte write enables, packed (BE=(MEM_DATAWIDTH+7)/8); all zero means read.
REQ-012 req_addr  in  NUM_REQ*MEM_ADDRWIDTH  packed word addresses.
REQ-013 req_wdata  in  NUM_REQ*MEM_DATAWIDTH  packed write data.
REQ-014 rsp_valid  out  NUM_REQ  one-hot read-data strobe, one cycle.
REQ-015 rsp_rdata  out  MEM_DATAWIDTH  read data, shared by all requesters.
REQ-016 mem_en, mem_we[BE], mem_addr, mem_din  out  RAM port controls.
REQ-017 mem_dout  in  MEM_DATAWIDTH  RAM read data, latency 1, no_change write mode.

Function
REQ-018 Requester i accepted when req_valid[i] and req_ready[i] both high on a rising clk edge.
REQ-019 req_ready combinational: asserted only for the winning requester; never depends on req_ready itself.
REQ-020 Winner = first valid requester scanning upward from rr_ptr, wrapping NUM_REQ-1 to 0.
REQ-021 Lock override: if lock_active and owner's req_valid high, owner wins regardless of rr_ptr.
REQ-022 On accept with owner's req_lock high and burst_cnt+1 < MAX_BURST: lock_active=1, burst_cnt+=1, rr_ptr unchanged.
REQ-023 On accept otherwise: lock_active=0, burst_cnt=0, rr_ptr=winner+1 mod NUM_REQ.
REQ-024 Lock released if owner drops req_valid while locked; same cycle arbitrates normally from rr_ptr.
REQ-025 mem_en = any accept; mem_we/mem_addr/mem_din = winner's fields in the same cycle; all zero when no accept.
REQ-026 Read accepted at cycle T: rsp_valid[winner] high at T+1, rsp_rdata = mem_dout at T+1.
REQ-027 Writes posted: no rsp_valid generated.
REQ-028 rsp_rdata SHALL equal mem_dout combinationally; only the response id/valid is registered.
REQ-029 Back-to-back reads from same or different requesters: one accept per cycle, full throughput.
REQ-030 No requester with req_valid held high waits more than (NUM_REQ-1)*MAX_BURST accepts.

Reset
REQ-031 While reset low: req_ready=0, mem_en=0, mem_we=0, rsp_valid=0.
REQ-032 Reset clears rr_ptr=0, burst_cnt=0, lock_active=0, pending response.
REQ-033 Reset asserted mid-burst or with a read in flight: response discarded, no rsp_valid after release.

Structure
REQ-034 Shared package mem_arb_pkg holds BE width function, burst counter width, requester-id width ($clog2(NUM_REQ)).
REQ-035 One sub-module rr_arbiter: rotating-priority one-hot select from valid vector and pointer, combinational.
REQ-036 Outputs to RAM drive xpm TDP port directly; no extra pipeline stage.

Verification
REQ-037 All 4 requesters read continuously, no lock -> grants 0,1,2,3,0 ...; rsp_valid one-hot matching each grant at T+1.
REQ-038 Req 1 writes 0xA5 bytes addr 0x10, then req 2 reads 0x10 -> rsp_valid[2] next cycle, rsp_rdata byte lanes 0xA5.
REQ-039 Req 0 lock held, valid held, MAX_BURST=8, req 3 waiting -> 8 consecutive grants to 0, then grant to 3.
REQ-040 Req 2 locked, drops req_valid after 3 accepts -> lock released, req 3 granted same cycle.
REQ-041 Reset low one cycle after a read accept -> no rsp_valid; after release rr_ptr=0, req 0 wins first.
REQ-042 Only req 3 valid, reads 10 cycles -> 10 accepts, 10 rsp_valid[3] pulses, mem_en never high without accept.
